// File: rtl/cell_check_pkg.sv
// Shared types and standard truth tables for the cell truth checkers.
// Bit i of a truth table is the expected Y when the cell inputs equal i.
package cell_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0] TT_INV   = 2'b01;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [7:0] TT_NAND3 = 8'b0111_1111;
  localparam logic [7:0] TT_NOR3  = 8'b0000_0001;

endpackage

// File: rtl/cell_check_settle_ctr.sv
// Settle-window down-counter: load arms a SETTLE-cycle window, and sample_c
// strobes on the last cycle of each window, then the counter re-arms itself.
module cell_check_settle_ctr #(
  parameter int unsigned SETTLE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic sample_c
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

  logic [CW-1:0] count;

  assign sample_c = en && (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load || sample_c) begin
      count <= RELOAD;
    end else if (en) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/cell_truth_checker.sv
// Exhaustive truth-table checker for single-output cells: steps A through all
// input codes, samples Y after a settle window, reports per-vector mismatches.
// Optional macro CELL_CHECK_X_DETECT_EN: X/Z on Y counts as a mismatch.
module cell_truth_checker
  import cell_check_pkg::*;
#(
  parameter int unsigned            N_IN   = 3,
  parameter int unsigned            SETTLE = 4,
  parameter logic [(2**N_IN)-1:0]   TRUTH  = TT_NOR3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic [N_IN-1:0]       A,
  input  logic                  Y,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [(2**N_IN)-1:0]  FAIL_VEC,
  output logic [N_IN:0]         ERR_CNT
);

  localparam int unsigned     NV       = 2 ** N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);

  if (N_IN < 1 || N_IN > 4) begin : g_bad_n_in
    $error("cell_truth_checker: N_IN must be 1..4");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("cell_truth_checker: SETTLE must be >= 1");
  end

  state_t          state, state_nxt;
  logic [N_IN-1:0] idx, idx_nxt;
  logic            busy_nxt;
  logic            done_nxt;
  logic            pass_nxt;
  logic [NV-1:0]   fail_vec_nxt;
  logic [N_IN:0]   err_cnt_nxt;
  logic            ctr_load;
  logic            ctr_en;
  logic            sample;
  logic            mismatch;

  // A is the vector index itself, so it stays registered.
  assign A = idx;

  cell_check_settle_ctr #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk      (CLK),
    .rst      (RST),
    .load     (ctr_load),
    .en       (ctr_en),
    .sample_c (sample)
  );

`ifdef CELL_CHECK_X_DETECT_EN
  // Floating or unknown outputs fail regardless of the expected value.
  assign mismatch = (Y === 1'bx) || (Y === 1'bz) || (Y != TRUTH[idx]);
`else
  assign mismatch = (Y != TRUTH[idx]);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
      FAIL_VEC <= '0;
      ERR_CNT  <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      BUSY     <= busy_nxt;
      DONE     <= done_nxt;
      PASS     <= pass_nxt;
      FAIL_VEC <= fail_vec_nxt;
      ERR_CNT  <= err_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    busy_nxt     = BUSY;
    done_nxt     = 1'b0;
    pass_nxt     = PASS;
    fail_vec_nxt = FAIL_VEC;
    err_cnt_nxt  = ERR_CNT;
    ctr_load     = 1'b0;
    ctr_en       = 1'b0;

    case (state)
      IDLE: begin
        if (START) begin
          state_nxt    = RUN;
          idx_nxt      = '0;
          busy_nxt     = 1'b1;
          pass_nxt     = 1'b0;
          fail_vec_nxt = '0;
          err_cnt_nxt  = '0;
          ctr_load     = 1'b1;
        end
      end

      RUN: begin
        ctr_en = 1'b1;
        if (sample) begin
          if (mismatch) begin
            fail_vec_nxt[idx] = 1'b1;
            err_cnt_nxt       = ERR_CNT + (N_IN + 1)'(1);
          end
          // PASS must include the verdict of the final vector.
          if (idx == LAST_IDX) begin
            state_nxt = FIN;
            idx_nxt   = '0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_cnt_nxt == '0);
          end else begin
            idx_nxt = idx + N_IN'(1);
          end
        end
      end

      FIN: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cell_truth_checker.sv
// Directed bench for cell_truth_checker with a NOR3 model and faulty-cell variants.
module tb_cell_truth_checker;
  import cell_check_pkg::*;

  localparam int unsigned N_IN    = 3;
  localparam int unsigned SETTLE  = 4;
  localparam int unsigned NV      = 8;
  localparam int unsigned RUN_CYC = NV * SETTLE;
  localparam int          MAX_CYC = 200;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [2:0] A;
  logic       Y;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [7:0] FAIL_VEC;
  logic [3:0] ERR_CNT;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         mode    = 0;
  int         done_seen = 0;
  logic [4:0] dl;

  typedef struct {
    string      name;
    int         mode;
    logic       pass;
    logic [7:0] fv;
    logic [3:0] err;
  } vec_t;

  vec_t tbl[4];

  always #5 CLK = ~CLK;

  cell_truth_checker #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE),
    .TRUTH  (TT_NOR3)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .A        (A),
    .Y        (Y),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .PASS     (PASS),
    .FAIL_VEC (FAIL_VEC),
    .ERR_CNT  (ERR_CNT)
  );

  // Slow cell: NOR3 of A seen 5 cycles late, output low while unpowered (idle).
  always_ff @(posedge CLK) dl <= {dl[3:0], BUSY & ~|A};

  always_comb begin
    case (mode)
      1:       Y = 1'b0;
      2:       Y = 1'b1;
      3:       Y = dl[4];
`ifdef CELL_CHECK_X_DETECT_EN
      4:       Y = (A == 3'd5) ? 1'bz : ~|A;
`endif
      default: Y = ~|A;
    endcase
  end

  always @(negedge CLK) if (DONE === 1'b1) done_seen++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for DONE from the negedge following a START edge.
  task automatic wait_done(input string name, output int k, output int a_bad);
    k = 0;
    a_bad = 0;
    while (DONE !== 1'b1 && k < MAX_CYC) begin
      if (BUSY !== 1'b1 || A !== 3'(k / SETTLE)) a_bad++;
      @(negedge CLK);
      k++;
    end
    check({name, "_a_seq"}, 32'(a_bad), 32'd0);
    check({name, "_done_lat"}, 32'(k), 32'(RUN_CYC));
  endtask

  task automatic run_one(input vec_t v);
    int k;
    int a_bad;
    mode = v.mode;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(v.name, k, a_bad);
    check({v.name, "_fin_busy"}, 32'(BUSY), 32'd0);
    check({v.name, "_fin_a"}, 32'(A), 32'd0);
    check({v.name, "_pass"}, 32'(PASS), 32'(v.pass));
    check({v.name, "_fail_vec"}, 32'(FAIL_VEC), 32'(v.fv));
    check({v.name, "_err_cnt"}, 32'(ERR_CNT), 32'(v.err));
    @(negedge CLK);
    check({v.name, "_done_pulse"}, 32'(DONE), 32'd0);
    repeat (3) @(negedge CLK);
    check({v.name, "_hold"}, {23'd0, PASS, FAIL_VEC}, {23'd0, v.pass, v.fv});
  endtask

  initial begin
    int k;
    int a_bad;
    int done_snap;
    vec_t xv;

    tbl[0] = '{name: "nor3_ok",   mode: 0, pass: 1'b1, fv: 8'b0000_0000, err: 4'd0};
    tbl[1] = '{name: "stuck0",    mode: 1, pass: 1'b0, fv: 8'b0000_0001, err: 4'd1};
    tbl[2] = '{name: "stuck1",    mode: 2, pass: 1'b0, fv: 8'b1111_1110, err: 4'd7};
    tbl[3] = '{name: "delayed5",  mode: 3, pass: 1'b0, fv: 8'b0000_0011, err: 4'd2};

    RST   = 1'b1;
    START = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_outputs", {20'd0, A, BUSY, DONE, PASS, ERR_CNT}, 32'd0);
    check("rst_fail_vec", 32'(FAIL_VEC), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 4; i++) run_one(tbl[i]);

`ifdef CELL_CHECK_X_DETECT_EN
    xv = '{name: "z_on_v5", mode: 4, pass: 1'b0, fv: 8'b0010_0000, err: 4'd1};
    run_one(xv);
`endif

    // START mid-run and during FIN must be ignored.
    mode = 1;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    k = 0;
    while (DONE !== 1'b1 && k < MAX_CYC) begin
      START = (k == 10);
      @(negedge CLK);
      k++;
    end
    check("restart_done_lat", 32'(k), 32'(RUN_CYC));
    check("restart_results", {20'd0, PASS, ERR_CNT, FAIL_VEC}, {20'd0, 1'b0, 4'd1, 8'b0000_0001});
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("fin_start_ign", {30'd0, BUSY, DONE}, 32'd0);
    @(negedge CLK);
    check("fin_start_idle", 32'(BUSY), 32'd0);

    // START held high: back-to-back runs with one IDLE cycle between.
    mode = 0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    wait_done("b2b_first", k, a_bad);
    check("b2b_first_pass", 32'(PASS), 32'd1);
    @(negedge CLK);
    check("b2b_idle_gap", {30'd0, BUSY, DONE}, 32'd0);
    @(negedge CLK);
    check("b2b_restart", {28'd0, BUSY, A}, {28'd0, 1'b1, 3'd0});
    START = 1'b0;
    wait_done("b2b_second", k, a_bad);
    check("b2b_second_pass", 32'(PASS), 32'd1);
    repeat (2) @(negedge CLK);

    // Reset at cycle 13 of a failing run aborts without a DONE pulse.
    mode = 2;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (13) @(negedge CLK);
    check("pre_rst_fail_vec", {24'd0, FAIL_VEC}, {24'd0, 8'b0000_0110});
    done_snap = done_seen;
    #2 RST = 1'b1;
    #1;
    check("rst_mid_outputs", {20'd0, A, BUSY, DONE, PASS, ERR_CNT}, 32'd0);
    check("rst_mid_fail_vec", 32'(FAIL_VEC), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (40) @(negedge CLK);
    check("rst_no_done", 32'(done_seen), 32'(done_snap));
    check("rst_stays_idle", 32'(BUSY), 32'd0);
    run_one('{name: "after_rst", mode: 0, pass: 1'b1, fv: 8'b0000_0000, err: 4'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
